// File: rtl/seg_scan_drv_pkg.sv
// seg_pkg: shared constants and helpers for the 4-digit 7-segment scan driver.
//   - Active-low segment codes for decimal digits 0..9, blank and dash.
//     Bit order is {dp, g, f, e, d, c, b, a}.
//   - DP_BIT: bit position of the decimal point in a segment code.
//   - digit_idx_t: digit position 0..3, where 3 is the leftmost digit.
//   - digit_code(): maps a BCD digit to its segment code.
package seg_pkg;

   localparam logic [7:0] SEG_D0    = 8'hC0;
   localparam logic [7:0] SEG_D1    = 8'hF9;
   localparam logic [7:0] SEG_D2    = 8'hA4;
   localparam logic [7:0] SEG_D3    = 8'hB0;
   localparam logic [7:0] SEG_D4    = 8'h99;
   localparam logic [7:0] SEG_D5    = 8'h92;
   localparam logic [7:0] SEG_D6    = 8'h82;
   localparam logic [7:0] SEG_D7    = 8'hF8;
   localparam logic [7:0] SEG_D8    = 8'h80;
   localparam logic [7:0] SEG_D9    = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam int DP_BIT = 7;

   typedef logic [1:0] digit_idx_t;

   // Codes 10..15 cannot occur for an in-range value; they map to blank.
   function automatic logic [7:0] digit_code(input logic [3:0] d);
      case (d)
         4'd0:    digit_code = SEG_D0;
         4'd1:    digit_code = SEG_D1;
         4'd2:    digit_code = SEG_D2;
         4'd3:    digit_code = SEG_D3;
         4'd4:    digit_code = SEG_D4;
         4'd5:    digit_code = SEG_D5;
         4'd6:    digit_code = SEG_D6;
         4'd7:    digit_code = SEG_D7;
         4'd8:    digit_code = SEG_D8;
         4'd9:    digit_code = SEG_D9;
         default: digit_code = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg_dec_enc.sv
// seg_dec_enc: combinational conversion of one 8-bit value into two
// active-low segment codes.
//   value     (in,  8): value to show; 0..99 is shown as two decimal digits,
//                       anything above 99 is shown as two dashes.
//   tens_code (out, 8): segment code for the tens digit.
//   ones_code (out, 8): segment code for the ones digit.
// Parameter BLANK_LZ: 1 = a tens digit of 0 is shown blank.
// The decimal point is never set here; the caller adds it where needed.
module seg_dec_enc
   import seg_pkg::*;
#(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic [7:0] value,
   output logic [7:0] tens_code,
   output logic [7:0] ones_code
);

   logic [3:0] tens;
   logic [3:0] ones;

   // Only meaningful when value <= 99, so both results fit in 4 bits.
   assign tens = 4'(value / 8'd10);
   assign ones = 4'(value % 8'd10);

   always_comb begin
      tens_code = SEG_DASH;
      ones_code = SEG_DASH;
      if (value <= 8'd99) begin
         ones_code = digit_code(ones);
         if (BLANK_LZ && (tens == 4'd0)) begin
            tens_code = SEG_BLANK;
         end else begin
            tens_code = digit_code(tens);
         end
      end
   end

endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: time-multiplexed driver for a 4-digit common-anode
// 7-segment display.
//   clk     (in,  1): system clock.
//   rst_n   (in,  1): synchronous active-low reset.
//   dat1    (in,  8): left value, shown on digits 3 (tens) and 2 (ones).
//   dat2    (in,  8): right value, shown on digits 1 (tens) and 0 (ones).
//   seg_out (out, 8): segment drive, active-low, {dp, g..a}.
//   sel     (out, 4): digit select, active-low one-hot, sel[3] = leftmost.
// Each digit owns a slot of SCAN_DIV cycles; the first DEAD_CYC cycles of a
// slot drive nothing so the previous digit's pattern cannot ghost onto the
// next one. The inputs are sampled only at the end of a frame (after
// digit 0), so a frame always shows one coherent pair of values.
// Outputs are registered: they reflect the slot position of the previous cycle.
module seg_scan_drv
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEAD_CYC = 16,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] dat1,
   input  logic [7:0] dat2,
   output logic [7:0] seg_out,
   output logic [3:0] sel
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   digit_idx_t    idx;
   logic [7:0]    v1;
   logic [7:0]    v2;

   logic          wrap;
   logic          dead;
   logic [7:0]    tens1, ones1, tens2, ones2;
   logic [7:0]    code;
   logic [3:0]    sel_next;
   logic [7:0]    seg_next;

   assign wrap = (cnt == CW'(SCAN_DIV - 1));

   // With no dead time the compare would be against zero and always false.
   generate
      if (DEAD_CYC == 0) begin : g_no_dead
         assign dead = 1'b0;
      end else begin : g_dead
         assign dead = (cnt < CW'(DEAD_CYC));
      end
   endgenerate

   seg_dec_enc #(.BLANK_LZ(BLANK_LZ)) u_enc_left (
      .value     (v1),
      .tens_code (tens1),
      .ones_code (ones1)
   );

   seg_dec_enc #(.BLANK_LZ(BLANK_LZ)) u_enc_right (
      .value     (v2),
      .tens_code (tens2),
      .ones_code (ones2)
   );

   always_comb begin
      code = SEG_BLANK;
      case (idx)
         2'd3: code = tens1;
         2'd2: begin
            // Separator dot between the two pairs, lit even over a dash.
            code         = ones1;
            code[DP_BIT] = 1'b0;
         end
         2'd1: code = tens2;
         2'd0: code = ones2;
         default: code = SEG_BLANK;
      endcase

      sel_next = 4'hF;
      seg_next = SEG_BLANK;
      if (!dead) begin
         sel_next = ~(4'b0001 << idx);
         seg_next = code;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         idx     <= 2'd3;
         v1      <= 8'd0;
         v2      <= 8'd0;
         sel     <= 4'hF;
         seg_out <= SEG_BLANK;
      end else begin
         sel     <= sel_next;
         seg_out <= seg_next;
         if (wrap) begin
            cnt <= '0;
            // 2-bit decrement gives 3->2->1->0->3 for free.
            idx <= idx - 2'd1;
            if (idx == 2'd0) begin
               v1 <= dat1;
               v2 <= dat2;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
